// File: rtl/calc_display_rx.sv
// Receiver for the calculator digit stream: captures BCD digits into a shadow buffer,
// commits whole 8-digit frames atomically and scans them onto a common-anode 7-segment display.
module calc_display_rx #(
    parameter int DATA_LAG      = 1,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [6:0] seg,
    output logic [7:0] an,
    output logic       frame_valid,
    output logic       err
);

    localparam int            PW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_O     = 7'b0100011;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_DASH;
        endcase
    endfunction

    logic       cap_en_now;
    logic       cap_en;
    logic [3:0] cap_pos;
    logic       wr;
    logic       commit;

    // Both busy and error states carry stream digits.
    assign cap_en_now = (status == 2'b01) || (status == 2'b00);

    generate
        if (DATA_LAG != 0) begin : g_lag
            logic       en_q;
            logic [3:0] pos_q;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    en_q  <= 1'b0;
                    pos_q <= 4'd0;
                end else begin
                    en_q  <= cap_en_now;
                    pos_q <= pos;
                end
            end
            assign cap_en  = en_q;
            assign cap_pos = pos_q;
        end else begin : g_nolag
            assign cap_en  = cap_en_now;
            assign cap_pos = pos;
        end
    endgenerate

    assign wr     = cap_en && !cap_pos[3];
    assign commit = wr && (cap_pos[2:0] == 3'd7);

    logic [3:0] shadow [8];
    logic [3:0] active [8];

    // Index 7 closes a frame: it reaches active directly alongside the older shadow digits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 4'd0;
                active[i] <= 4'd0;
            end
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= commit;
            if (wr) begin
                shadow[cap_pos[2:0]] <= data;
            end
            if (commit) begin
                for (int i = 0; i < 7; i++) begin
                    active[i] <= shadow[i];
                end
                active[7] <= data;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (status == 2'b00) begin
            err <= 1'b1;
        end
    end

    logic [PW-1:0] prescale;
    logic [2:0]    scan;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescale <= '0;
            scan     <= 3'd0;
        end else if (prescale == PRE_LAST) begin
            prescale <= '0;
            scan     <= scan + 3'd1;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    logic [7:0] nz;
    logic [7:0] lead_blank;
    logic [6:0] disp_seg;

    // A digit is a leading zero when it and every more significant digit are zero.
    always_comb begin
        nz         = 8'd0;
        lead_blank = 8'd0;
        for (int i = 0; i < 8; i++) begin
            nz[i] = (active[i] != 4'd0);
        end
        for (int i = 1; i < 8; i++) begin
            lead_blank[i] = (BLANK_LEADING != 0) && ((nz >> i) == 8'd0);
        end
    end

    always_comb begin
        disp_seg = SEG_BLANK;
        if (err) begin
            case (scan)
                3'd3:       disp_seg = SEG_E;
                3'd2, 3'd1: disp_seg = SEG_R;
                3'd0:       disp_seg = SEG_O;
                default:    disp_seg = SEG_BLANK;
            endcase
        end else if (!lead_blank[scan]) begin
            disp_seg = seg_code(active[scan]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg <= SEG_BLANK;
            an  <= 8'hFF;
        end else begin
            seg <= disp_seg;
            an  <= ~(8'b1 << scan);
        end
    end

endmodule

// File: tb/tb_calc_display_rx.sv
// Bench for calc_display_rx: streams digit frames, tracks expected commits in a queue
// and compares every scanned digit slot against an independently built display model.
module tb_calc_display_rx;
  localparam int RDIV = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [6:0] seg;
  logic [7:0] an;
  logic       frame_valid;
  logic       err;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] sh_model;
  logic [31:0] cur_frame;
  logic        err_model;

  calc_display_rx #(
    .DATA_LAG(1),
    .REFRESH_DIV(RDIV),
    .BLANK_LEADING(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .status(status),
    .data(data),
    .pos(pos),
    .seg(seg),
    .an(an),
    .frame_valid(frame_valid),
    .err(err)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // frame commit monitor: each pulse must match a queued expected frame
  always @(negedge clock) begin
    if (reset && frame_valid) begin
      pulse_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_pulse: got frame_valid=1 required no commit pending");
      end else begin
        cur_frame = exp_q.pop_front();
      end
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'b1000000;
      4'd1: enc = 7'b1111001;
      4'd2: enc = 7'b0100100;
      4'd3: enc = 7'b0110000;
      4'd4: enc = 7'b0011001;
      4'd5: enc = 7'b0010010;
      4'd6: enc = 7'b0000010;
      4'd7: enc = 7'b1111000;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0010000;
      default: enc = 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [31:0] f, input logic e, input int k);
    logic lead;
    if (e) begin
      if (k == 3) return 7'b0000110;
      if (k == 2 || k == 1) return 7'b0101111;
      if (k == 0) return 7'b0100011;
      return 7'b1111111;
    end
    lead = (k > 0);
    for (int j = k; j < 8; j++) if (f[4*j +: 4] != 4'd0) lead = 1'b0;
    if (lead) return 7'b1111111;
    return enc(f[4*k +: 4]);
  endfunction

  // driver: entry i of plist is driven as pos, entry i of dlist follows one cycle later as data
  task automatic drive_stream(input int n, input logic [63:0] plist, input logic [63:0] dlist);
    logic [3:0] p;
    logic [3:0] d;
    for (int i = 0; i <= n; i++) begin
      @(negedge clock);
      if (i < n) begin
        status = 2'b01;
        pos = plist[4*i +: 4];
      end else begin
        status = 2'b10;
        pos = 4'd0;
      end
      if (i > 0) begin
        p = plist[4*(i-1) +: 4];
        d = dlist[4*(i-1) +: 4];
        data = d;
        if (p <= 4'd7) begin
          sh_model[4*p +: 4] = d;
          if (p == 4'd7) exp_q.push_back(sh_model);
        end
      end else begin
        data = 4'd0;
      end
    end
    @(negedge clock);
    status = 2'b10;
  endtask

  // collects the segment pattern shown in each digit slot over a full scan
  task automatic capture_display(output logic [55:0] segs, output logic ok);
    logic [7:0] seen;
    logic [7:0] pat;
    seen = 8'd0;
    segs = '1;
    for (int c = 0; c < RDIV * 8 * 3 && seen != 8'hFF; c++) begin
      @(negedge clock);
      for (int k = 0; k < 8; k++) begin
        pat = ~(8'b1 << k);
        if (an == pat) begin
          segs[7*k +: 7] = seg;
          seen[k] = 1'b1;
        end
      end
    end
    ok = (seen == 8'hFF);
  endtask

  task automatic test_reset();
    logic [55:0] segs;
    logic ok;
    logic [6:0] exp_s;
    reset = 1'b0;
    status = 2'b00;
    repeat (3) @(negedge clock);
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h required 7f", seg); end
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h required ff", an); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b required 0", frame_valid); end
    status = 2'b10;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (an !== 8'hFE) begin errors++; $display("FAIL first_an: got %h required fe", an); end
    checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL first_seg: got %b required 1000000", seg); end
    capture_display(segs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reset_scan: not every digit slot was seen"); end
    for (int k = 0; k < 8; k++) begin
      exp_s = exp_seg(32'h0, 1'b0, k);
      checks++;
      if (segs[7*k +: 7] !== exp_s) begin
        errors++; $display("FAIL reset_digit%0d: got %b required %b", k, segs[7*k +: 7], exp_s);
      end
    end
  endtask

  task automatic test_frame();
    logic [55:0] segs;
    logic ok;
    logic [6:0] exp_s;
    int p0;
    p0 = pulse_cnt;
    drive_stream(8, 64'h76543210, 64'h00012345);
    repeat (2) @(negedge clock);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL frame_pulses: got %0d required 1", pulse_cnt - p0); end
    capture_display(segs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_scan: not every digit slot was seen"); end
    for (int k = 0; k < 8; k++) begin
      exp_s = exp_seg(cur_frame, err_model, k);
      checks++;
      if (segs[7*k +: 7] !== exp_s) begin
        errors++; $display("FAIL frame_digit%0d: got %b required %b", k, segs[7*k +: 7], exp_s);
      end
    end
  endtask

  task automatic test_partial();
    logic [55:0] segs;
    logic ok;
    logic [6:0] exp_s;
    int p0;
    p0 = pulse_cnt;
    drive_stream(5, 64'h43210, 64'h98765);
    repeat (2) @(negedge clock);
    checks++; if (pulse_cnt != p0) begin errors++; $display("FAIL partial_pulses: got %0d required 0", pulse_cnt - p0); end
    capture_display(segs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL partial_scan: not every digit slot was seen"); end
    for (int k = 0; k < 8; k++) begin
      exp_s = exp_seg(cur_frame, err_model, k);
      checks++;
      if (segs[7*k +: 7] !== exp_s) begin
        errors++; $display("FAIL partial_digit%0d: got %b required %b", k, segs[7*k +: 7], exp_s);
      end
    end
    // finishing the frame commits the digits left in shadow by the partial stream
    drive_stream(3, 64'h765, 64'h000);
    repeat (2) @(negedge clock);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL resume_pulses: got %0d required 1", pulse_cnt - p0); end
    capture_display(segs, ok);
    for (int k = 0; k < 8; k++) begin
      exp_s = exp_seg(cur_frame, err_model, k);
      checks++;
      if (segs[7*k +: 7] !== exp_s) begin
        errors++; $display("FAIL resume_digit%0d: got %b required %b", k, segs[7*k +: 7], exp_s);
      end
    end
  endtask

  task automatic test_bad_digit();
    logic [55:0] segs;
    logic ok;
    logic [6:0] exp_s;
    int p0;
    p0 = pulse_cnt;
    drive_stream(8, 64'h76543210, 64'h12345C78);
    repeat (2) @(negedge clock);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL dash_pulses: got %0d required 1", pulse_cnt - p0); end
    capture_display(segs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dash_scan: not every digit slot was seen"); end
    for (int k = 0; k < 8; k++) begin
      exp_s = exp_seg(cur_frame, err_model, k);
      checks++;
      if (segs[7*k +: 7] !== exp_s) begin
        errors++; $display("FAIL dash_digit%0d: got %b required %b", k, segs[7*k +: 7], exp_s);
      end
    end
    p0 = pulse_cnt;
    drive_stream(2, 64'hF9, 64'h33);
    drive_stream(1, 64'h7, 64'h6);
    repeat (2) @(negedge clock);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL oob_pulses: got %0d required 1", pulse_cnt - p0); end
    capture_display(segs, ok);
    for (int k = 0; k < 8; k++) begin
      exp_s = exp_seg(cur_frame, err_model, k);
      checks++;
      if (segs[7*k +: 7] !== exp_s) begin
        errors++; $display("FAIL oob_digit%0d: got %b required %b", k, segs[7*k +: 7], exp_s);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] segs;
    logic ok;
    logic [6:0] exp_s;
    int p0;
    p0 = pulse_cnt;
    // second frame repeats index 1 and skips index 6
    drive_stream(16, {32'h75432110, 32'h76543210}, {32'h87654321, 32'h11112222});
    repeat (2) @(negedge clock);
    checks++; if (pulse_cnt - p0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d required 2", pulse_cnt - p0); end
    capture_display(segs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_scan: not every digit slot was seen"); end
    for (int k = 0; k < 8; k++) begin
      exp_s = exp_seg(cur_frame, err_model, k);
      checks++;
      if (segs[7*k +: 7] !== exp_s) begin
        errors++; $display("FAIL b2b_digit%0d: got %b required %b", k, segs[7*k +: 7], exp_s);
      end
    end
  endtask

  task automatic test_error();
    logic [55:0] segs;
    logic ok;
    logic [6:0] exp_s;
    int p0;
    @(negedge clock);
    status = 2'b00;
    pos = 4'hF;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before: got %b required 0", err); end
    @(negedge clock);
    status = 2'b10;
    pos = 4'd0;
    err_model = 1'b1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b required 1", err); end
    repeat (6) @(negedge clock);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", err); end
    capture_display(segs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL err_scan: not every digit slot was seen"); end
    for (int k = 0; k < 8; k++) begin
      exp_s = exp_seg(cur_frame, err_model, k);
      checks++;
      if (segs[7*k +: 7] !== exp_s) begin
        errors++; $display("FAIL err_digit%0d: got %b required %b", k, segs[7*k +: 7], exp_s);
      end
    end
    p0 = pulse_cnt;
    drive_stream(8, 64'h76543210, 64'h22222222);
    repeat (2) @(negedge clock);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL err_pulses: got %0d required 1", pulse_cnt - p0); end
    capture_display(segs, ok);
    for (int k = 0; k < 8; k++) begin
      exp_s = exp_seg(cur_frame, err_model, k);
      checks++;
      if (segs[7*k +: 7] !== exp_s) begin
        errors++; $display("FAIL err_hold_digit%0d: got %b required %b", k, segs[7*k +: 7], exp_s);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [55:0] segs;
    logic ok;
    logic [6:0] exp_s;
    int p0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      status = 2'b01;
      pos = 4'(i);
      data = 4'h5;
    end
    @(negedge clock);
    reset = 1'b0;
    status = 2'b10;
    sh_model = 32'h0;
    cur_frame = 32'h0;
    err_model = 1'b0;
    @(negedge clock);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b required 0", err); end
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL midrst_an: got %h required ff", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL midrst_seg: got %h required 7f", seg); end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    p0 = pulse_cnt;
    drive_stream(8, 64'h76543210, 64'h99999999);
    repeat (2) @(negedge clock);
    checks++; if (pulse_cnt - p0 != 1) begin errors++; $display("FAIL midrst_pulses: got %0d required 1", pulse_cnt - p0); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err_after: got %b required 0", err); end
    capture_display(segs, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_scan: not every digit slot was seen"); end
    for (int k = 0; k < 8; k++) begin
      exp_s = exp_seg(cur_frame, err_model, k);
      checks++;
      if (segs[7*k +: 7] !== exp_s) begin
        errors++; $display("FAIL midrst_digit%0d: got %b required %b", k, segs[7*k +: 7], exp_s);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    status = 2'b10;
    data = 4'd0;
    pos = 4'd0;
    sh_model = 32'h0;
    cur_frame = 32'h0;
    err_model = 1'b0;
    test_reset();
    test_frame();
    test_partial();
    test_bad_digit();
    test_back_to_back();
    test_error();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_frames: got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
